note_judge: RTL and testbench
=============================

NOTE_JUDGE -- requirements
Module: note_judge

Interface
REQ-001 SHALL have parameter PERFECT_WIN, default 3, the PERFECT window half-width in frames.
REQ-002 SHALL have parameter GOOD_WIN, default 6, the GOOD/miss window half-width in frames; GOOD_WIN > PERFECT_WIN.
REQ-003 SHALL have ports in this order:
  Clk  in  1  system clock; one clock domain
  Reset  in  1  asynchronous, active-high reset
  start  in  1  one-cycle pulse that begins the chart from IDLE
  frame_tick  in  1  one-cycle pulse per 60 Hz frame
  key_down  in  1  lane key level, synchronous to Clk
  key_1  in  16  chart entry at addr: [15:14] type, [13:0] frame time
  key_2  in  16  chart entry at addr+1
  addr  out  8  chart read pointer
  song_time  out  14  current frame count
  judge_valid  out  1  one-cycle judgment strobe
  judge_result  out  2  00 none, 01 PERFECT, 10 GOOD, 11 MISS
  combo  out  10  current combo
  hold_active  out  1  a hold note is being held
  score  out  16  accumulated score
  done  out  1  chart finished

Function
REQ-004 SHALL decode the type field as 00 tap, 01 hold-start, 10 hold-end, 11 end marker; charts SHALL terminate with type 11.
REQ-005 SHALL implement states IDLE, PLAY, HOLD and DONE: IDLE->PLAY on start; PLAY->HOLD on a judged hold-start; HOLD->PLAY on hold-end judgment; PLAY->DONE when key_1 type is 11 or addr is 252.
REQ-006 SHALL increment song_time on each frame_tick in PLAY or HOLD, saturating at 16383, and SHALL hold it in IDLE and DONE.
REQ-007 SHALL detect a press as a rising edge of registered key_down; delta = song_time - key_1 time (signed).
REQ-008 SHALL, in PLAY, on a press with |delta| <= PERFECT_WIN judge PERFECT, else with |delta| <= GOOD_WIN judge GOOD, and otherwise ignore the press with no penalty.
REQ-009 SHALL, in PLAY, on a frame_tick with delta > GOOD_WIN judge MISS and advance; a hold-start miss SHALL advance addr by 2, skipping its hold-end.
REQ-010 SHALL assert judge_valid with judge_result on the cycle after the deciding edge, and SHALL update addr (+1 per judged entry) on that same cycle.
REQ-011 SHALL, in HOLD, judge the release of key_down against the key_1 hold-end time using REQ-008 windows; a release with delta < -GOOD_WIN SHALL judge MISS.
REQ-012 SHALL, in HOLD with key_down still high when delta reaches 0, judge PERFECT automatically.
REQ-013 SHALL give a press precedence over a frame_tick in the same cycle, evaluating it against the pre-increment song_time.
REQ-014 SHALL increment combo on PERFECT or GOOD, saturating at 1023, and clear it on MISS.
REQ-015 SHALL assert hold_active exactly while in HOLD.
REQ-016 SHALL assert done only in DONE, ignoring further start pulses until Reset.

Reset
REQ-017 SHALL on Reset, at any time including mid-hold, force IDLE and set addr, song_time, judge_valid, judge_result, combo, hold_active, score and done to 0.

Configuration
REQ-018 SHALL, with JUDGE_SCORE_EN defined, add 2 per PERFECT and 1 per GOOD to score, saturating at 16'hFFFF.
REQ-019 SHALL, without JUDGE_SCORE_EN, keep the score port present and drive it constant 0.

Structure
REQ-020 SHALL place the note-type enum, the judgment enum, TIME_W=14 and the field bit positions in the shared package rhythm_pkg.
REQ-021 SHALL implement delta classification as the combinational sub-module judge_window, instantiated once.

Verification
REQ-022 SHALL cover: key_1=16'h0032 (tap, t=50), press at song_time 51 -> PERFECT, addr 0->1, combo 1.
REQ-023 SHALL cover: same note, press at 45 -> GOOD; press at 40 -> ignored, no judge_valid.
REQ-024 SHALL cover: no press, frame_tick moves song_time 56->57 -> MISS, combo cleared to 0; frame_tick and press in one cycle at 56 -> GOOD.
REQ-025 SHALL cover: key_1=16'h42A8 (t=680) and key_2=16'h82B8 (t=696), press at 680 -> PERFECT and hold_active=1; release at 690 -> GOOD; release at 685 instead -> MISS and combo 0.
REQ-026 SHALL cover: Reset asserted mid-HOLD -> all outputs 0 and state IDLE; key_1=16'hC000 -> done=1 and song_time frozen.

Source files
------------

// File: rtl/rhythm_pkg.sv
// ============================================================================
// Module   : rhythm_pkg
// Summary  : Shared chart-entry field layout, note/judgment/state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rhythm_pkg;

    localparam int TIME_W  = 14;
    localparam int TYPE_HI = 15;
    localparam int TYPE_LO = 14;
    localparam int TIME_HI = 13;
    localparam int TIME_LO = 0;

    localparam logic [7:0]        ADDR_LAST     = 8'd252;
    localparam logic [TIME_W-1:0] SONG_TIME_MAX = '1;
    localparam logic [9:0]        COMBO_MAX     = '1;

    typedef enum logic [1:0] {
        NOTE_TAP        = 2'b00,
        NOTE_HOLD_START = 2'b01,
        NOTE_HOLD_END   = 2'b10,
        NOTE_END        = 2'b11
    } note_type_e;

    typedef enum logic [1:0] {
        JUDGE_NONE    = 2'b00,
        JUDGE_PERFECT = 2'b01,
        JUDGE_GOOD    = 2'b10,
        JUDGE_MISS    = 2'b11
    } judge_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

`default_nettype wire

// File: rtl/judge_window.sv
// ============================================================================
// Module   : judge_window
// Summary  : Combinational classification of a signed timing delta against
//            the PERFECT and GOOD windows.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module judge_window
    import rhythm_pkg::*;
#(
    parameter int PERFECT_WIN = 3,
    parameter int GOOD_WIN    = 6
) (
    input  logic [TIME_W:0] delta,
    output logic            in_perfect,
    output logic            in_good,
    output logic            late
);

    localparam logic signed [TIME_W:0] c_perfect_hi = (TIME_W+1)'(PERFECT_WIN);
    localparam logic signed [TIME_W:0] c_perfect_lo = -c_perfect_hi;
    localparam logic signed [TIME_W:0] c_good_hi    = (TIME_W+1)'(GOOD_WIN);
    localparam logic signed [TIME_W:0] c_good_lo    = -c_good_hi;

    logic signed [TIME_W:0] w_delta;

    assign w_delta    = $signed(delta);
    assign in_perfect = (w_delta >= c_perfect_lo) && (w_delta <= c_perfect_hi);
    // GOOD window is inclusive of the PERFECT window.
    assign in_good    = (w_delta >= c_good_lo) && (w_delta <= c_good_hi);
    assign late       = (w_delta > c_good_hi);

endmodule

`default_nettype wire

// File: rtl/note_judge.sv
// ============================================================================
// Module   : note_judge
// Summary  : Single-lane rhythm-game note judge for tap/hold charts.
//            Define JUDGE_SCORE_EN to enable score accumulation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_judge
    import rhythm_pkg::*;
#(
    parameter int PERFECT_WIN = 3,
    parameter int GOOD_WIN    = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        frame_tick,
    input  logic        key_down,
    input  logic [15:0] key_1,
    input  logic [15:0] key_2,
    output logic [7:0]  addr,
    output logic [13:0] song_time,
    output logic        judge_valid,
    output logic [1:0]  judge_result,
    output logic [9:0]  combo,
    output logic        hold_active,
    output logic [15:0] score,
    output logic        done
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_key_q;
    logic [7:0]         r_addr;
    logic [TIME_W-1:0]  r_song_time;
    logic               r_judge_valid;
    judge_e             r_judge_result;
    logic [9:0]         r_combo;

    note_type_e         w_note_type;
    note_type_e         w_next_type;
    logic [TIME_W-1:0]  w_note_time;
    logic [TIME_W-1:0]  w_time_next;
    logic [TIME_W-1:0]  w_time_eval;
    logic [TIME_W:0]    w_delta;
    logic               w_press;
    logic               w_release;
    logic               w_tick_en;
    logic               w_in_perfect;
    logic               w_in_good;
    logic               w_late;
    judge_e             w_judge;
    logic [1:0]         w_addr_inc;
    logic               w_unused_key2_time;

    assign w_note_type        = note_type_e'(key_1[TYPE_HI:TYPE_LO]);
    assign w_next_type        = note_type_e'(key_2[TYPE_HI:TYPE_LO]);
    assign w_note_time        = key_1[TIME_HI:TIME_LO];
    assign w_unused_key2_time = ^key_2[TIME_HI:TIME_LO];

    assign w_press   = key_down & ~r_key_q;
    assign w_release = ~key_down & r_key_q;
    assign w_tick_en = frame_tick && ((r_state == ST_PLAY) || (r_state == ST_HOLD));

    assign w_time_next = (frame_tick && (r_song_time != SONG_TIME_MAX))
                         ? r_song_time + 14'd1 : r_song_time;

    // A press is judged against the pre-tick time; a late-miss check in PLAY
    // looks at the time this tick is about to produce.
    assign w_time_eval = ((r_state == ST_PLAY) && !w_press) ? w_time_next : r_song_time;
    assign w_delta     = {1'b0, w_time_eval} - {1'b0, w_note_time};

    judge_window #(
        .PERFECT_WIN (PERFECT_WIN),
        .GOOD_WIN    (GOOD_WIN)
    ) u_judge_window (
        .delta      (w_delta),
        .in_perfect (w_in_perfect),
        .in_good    (w_in_good),
        .late       (w_late)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_judge     = JUDGE_NONE;
        w_addr_inc  = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if ((w_note_type == NOTE_END) || (r_addr == ADDR_LAST)) begin
                    w_state_nxt = ST_DONE;
                end else if (w_press) begin
                    if (w_in_good) begin
                        w_judge    = w_in_perfect ? JUDGE_PERFECT : JUDGE_GOOD;
                        w_addr_inc = 2'd1;
                        if (w_note_type == NOTE_HOLD_START) begin
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end else if (frame_tick && w_late) begin
                    w_judge = JUDGE_MISS;
                    // A missed hold-start also discards its paired hold-end.
                    if ((w_note_type == NOTE_HOLD_START) && (w_next_type == NOTE_HOLD_END)) begin
                        w_addr_inc = 2'd2;
                    end else begin
                        w_addr_inc = 2'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_release) begin
                    if (w_in_perfect) begin
                        w_judge = JUDGE_PERFECT;
                    end else if (w_in_good) begin
                        w_judge = JUDGE_GOOD;
                    end else begin
                        w_judge = JUDGE_MISS;
                    end
                    w_addr_inc  = 2'd1;
                    w_state_nxt = ST_PLAY;
                end else if (key_down && (w_delta == '0)) begin
                    w_judge     = JUDGE_PERFECT;
                    w_addr_inc  = 2'd1;
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_key_q        <= 1'b0;
            r_addr         <= '0;
            r_song_time    <= '0;
            r_judge_valid  <= 1'b0;
            r_judge_result <= JUDGE_NONE;
            r_combo        <= '0;
        end else begin
            r_key_q        <= key_down;
            r_judge_valid  <= (w_judge != JUDGE_NONE);
            r_judge_result <= w_judge;
            r_addr         <= r_addr + {6'd0, w_addr_inc};
            if (w_tick_en) begin
                r_song_time <= w_time_next;
            end
            if (w_judge == JUDGE_MISS) begin
                r_combo <= '0;
            end else if ((w_judge != JUDGE_NONE) && (r_combo != COMBO_MAX)) begin
                r_combo <= r_combo + 10'd1;
            end
        end
    end

`ifdef JUDGE_SCORE_EN
    logic [15:0] r_score;
    logic [16:0] w_score_sum;

    always_comb begin
        w_score_sum = {1'b0, r_score};
        if (w_judge == JUDGE_PERFECT) begin
            w_score_sum = {1'b0, r_score} + 17'd2;
        end else if (w_judge == JUDGE_GOOD) begin
            w_score_sum = {1'b0, r_score} + 17'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_score <= '0;
        end else begin
            r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        end
    end

    assign score = r_score;
`else
    assign score = 16'd0;
`endif

    assign addr         = r_addr;
    assign song_time    = r_song_time;
    assign judge_valid  = r_judge_valid;
    assign judge_result = r_judge_result;
    assign combo        = r_combo;
    assign hold_active  = (r_state == ST_HOLD);
    assign done         = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_note_judge.sv
// ============================================================================
// Module   : tb_note_judge
// Summary  : Self-checking bench for note_judge: directed scenarios plus a
//            randomized tap chart checked against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_note_judge;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        frame_tick;
    logic        key_down;
    logic [15:0] key_1;
    logic [15:0] key_2;
    logic [7:0]  addr;
    logic [13:0] song_time;
    logic        judge_valid;
    logic [1:0]  judge_result;
    logic [9:0]  combo;
    logic        hold_active;
    logic [15:0] score;
    logic        done;

    logic [15:0] chart [0:255];
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    assign key_1 = chart[addr];
    assign key_2 = chart[addr + 8'd1];

    note_judge #(.PERFECT_WIN(3), .GOOD_WIN(6)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start),
        .frame_tick   (frame_tick),
        .key_down     (key_down),
        .key_1        (key_1),
        .key_2        (key_2),
        .addr         (addr),
        .song_time    (song_time),
        .judge_valid  (judge_valid),
        .judge_result (judge_result),
        .combo        (combo),
        .hold_active  (hold_active),
        .score        (score),
        .done         (done)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic clear_chart();
        for (int i = 0; i < 256; i++) chart[i] = 16'hC000;
    endtask

    task automatic restart();
        key_down   = 1'b0;
        frame_tick = 1'b0;
        Reset      = 1'b1;
        step();
        Reset = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic advance_to(input int target);
        for (int k = 0; k < 20000 && int'(song_time) != target; k++) tick();
        checks++;
        if (int'(song_time) != target) begin
            errors++;
            $display("FAIL advance_timeout: song_time %0d required %0d", song_time, target);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        checks++; if (addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr); end
        checks++; if (song_time !== 14'd0) begin errors++; $display("FAIL reset_time: got %0d want 0", song_time); end
        checks++; if (judge_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", judge_valid); end
        checks++; if (judge_result !== 2'b00) begin errors++; $display("FAIL reset_result: got %b want 00", judge_result); end
        checks++; if (combo !== 10'd0) begin errors++; $display("FAIL reset_combo: got %0d want 0", combo); end
        checks++; if (hold_active !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b want 0", hold_active); end
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        Reset = 1'b0;
        step();
        tick(); tick(); tick();
        checks++;
        if (song_time !== 14'd0) begin errors++; $display("FAIL idle_time_hold: got %0d want 0", song_time); end
    endtask

    task automatic test_tap_perfect();
        clear_chart();
        chart[0] = 16'h0032;
        chart[1] = 16'h0064;
        restart();
        advance_to(51);
        key_down = 1'b1;
        step();
        checks++;
        if (judge_valid !== 1'b1 || judge_result !== 2'b01) begin
            errors++; $display("FAIL tap_perfect: valid %b result %b want 1 01", judge_valid, judge_result);
        end
        checks++; if (addr !== 8'd1) begin errors++; $display("FAIL tap_perfect_addr: got %0d want 1", addr); end
        checks++; if (combo !== 10'd1) begin errors++; $display("FAIL tap_perfect_combo: got %0d want 1", combo); end
        key_down = 1'b0;
        step();
        checks++;
        if (judge_valid !== 1'b0) begin errors++; $display("FAIL strobe_width: valid %b want 0", judge_valid); end
    endtask

    task automatic test_tap_good_ignore();
        logic seen;
        clear_chart();
        chart[0] = 16'h0032;
        chart[1] = 16'h0064;
        restart();
        advance_to(40);
        key_down = 1'b1;
        step();
        seen = judge_valid;
        for (int k = 0; k < 3; k++) begin step(); seen = seen | judge_valid; end
        key_down = 1'b0;
        step();
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL early_press_ignored: valid seen %b want 0", seen); end
        checks++; if (addr !== 8'd0) begin errors++; $display("FAIL early_press_addr: got %0d want 0", addr); end
        advance_to(45);
        key_down = 1'b1;
        step();
        checks++;
        if (judge_valid !== 1'b1 || judge_result !== 2'b10) begin
            errors++; $display("FAIL tap_good: valid %b result %b want 1 10", judge_valid, judge_result);
        end
        checks++;
        if (addr !== 8'd1 || combo !== 10'd1) begin
            errors++; $display("FAIL tap_good_state: addr %0d combo %0d want 1 1", addr, combo);
        end
        key_down = 1'b0;
        step();
    endtask

    task automatic test_miss();
        clear_chart();
        chart[0] = 16'h0014;
        chart[1] = 16'h0032;
        chart[2] = 16'h00C8;
        restart();
        advance_to(20);
        key_down = 1'b1;
        step();
        key_down = 1'b0;
        step();
        checks++; if (combo !== 10'd1) begin errors++; $display("FAIL miss_setup_combo: got %0d want 1", combo); end
        advance_to(56);
        checks++;
        if (addr !== 8'd1) begin errors++; $display("FAIL no_early_miss: addr %0d want 1", addr); end
        tick();
        checks++;
        if (judge_valid !== 1'b1 || judge_result !== 2'b11) begin
            errors++; $display("FAIL tick_miss: valid %b result %b want 1 11", judge_valid, judge_result);
        end
        checks++;
        if (song_time !== 14'd57 || combo !== 10'd0 || addr !== 8'd2) begin
            errors++; $display("FAIL tick_miss_state: time %0d combo %0d addr %0d want 57 0 2", song_time, combo, addr);
        end

        clear_chart();
        chart[0] = 16'h0032;
        chart[1] = 16'h0064;
        restart();
        advance_to(56);
        frame_tick = 1'b1;
        key_down   = 1'b1;
        step();
        frame_tick = 1'b0;
        checks++;
        if (judge_valid !== 1'b1 || judge_result !== 2'b10) begin
            errors++; $display("FAIL press_tick_same: valid %b result %b want 1 10", judge_valid, judge_result);
        end
        checks++;
        if (song_time !== 14'd57 || addr !== 8'd1) begin
            errors++; $display("FAIL press_tick_state: time %0d addr %0d want 57 1", song_time, addr);
        end
        key_down = 1'b0;
        step();
    endtask

    task automatic hold_setup();
        clear_chart();
        chart[0] = 16'h42A8;
        chart[1] = 16'h82B8;
        restart();
        advance_to(680);
        key_down = 1'b1;
        step();
    endtask

    task automatic test_hold();
        hold_setup();
        checks++;
        if (judge_valid !== 1'b1 || judge_result !== 2'b01 || hold_active !== 1'b1) begin
            errors++; $display("FAIL hold_start: valid %b result %b hold %b want 1 01 1", judge_valid, judge_result, hold_active);
        end
        advance_to(690);
        checks++;
        if (hold_active !== 1'b1 || addr !== 8'd1) begin
            errors++; $display("FAIL hold_keep: hold %b addr %0d want 1 1", hold_active, addr);
        end
        key_down = 1'b0;
        step();
        checks++;
        if (judge_valid !== 1'b1 || judge_result !== 2'b10) begin
            errors++; $display("FAIL hold_release_good: valid %b result %b want 1 10", judge_valid, judge_result);
        end
        checks++;
        if (hold_active !== 1'b0 || addr !== 8'd2 || combo !== 10'd2) begin
            errors++; $display("FAIL hold_release_state: hold %b addr %0d combo %0d want 0 2 2", hold_active, addr, combo);
        end

        hold_setup();
        advance_to(685);
        key_down = 1'b0;
        step();
        checks++;
        if (judge_valid !== 1'b1 || judge_result !== 2'b11) begin
            errors++; $display("FAIL hold_release_miss: valid %b result %b want 1 11", judge_valid, judge_result);
        end
        checks++;
        if (combo !== 10'd0 || hold_active !== 1'b0) begin
            errors++; $display("FAIL hold_miss_state: combo %0d hold %b want 0 0", combo, hold_active);
        end
    endtask

    task automatic test_hold_auto();
        logic       got;
        logic [1:0] res;
        hold_setup();
        advance_to(696);
        got = 1'b0;
        res = 2'b00;
        for (int k = 0; k < 6 && !got; k++) begin
            step();
            if (judge_valid === 1'b1) begin got = 1'b1; res = judge_result; end
        end
        checks++;
        if (got !== 1'b1 || res !== 2'b01) begin
            errors++; $display("FAIL hold_auto: seen %b result %b want 1 01", got, res);
        end
        checks++;
        if (hold_active !== 1'b0 || combo !== 10'd2) begin
            errors++; $display("FAIL hold_auto_state: hold %b combo %0d want 0 2", hold_active, combo);
        end
        key_down = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_hold();
        hold_setup();
        Reset = 1'b1;
        #2;
        checks++;
        if (hold_active !== 1'b0 || addr !== 8'd0 || song_time !== 14'd0 || combo !== 10'd0 ||
            judge_valid !== 1'b0 || judge_result !== 2'b00 || score !== 16'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: hold %b addr %0d time %0d combo %0d valid %b result %b score %0d done %b want all 0",
                     hold_active, addr, song_time, combo, judge_valid, judge_result, score, done);
        end
        key_down = 1'b0;
        step();
        Reset = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (song_time !== 14'd0 || hold_active !== 1'b0) begin
            errors++; $display("FAIL reset_to_idle: time %0d hold %b want 0 0", song_time, hold_active);
        end
    endtask

    task automatic test_end_marker();
        clear_chart();
        restart();
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL end_marker_done: got %b want 1", done); end
        tick(); tick(); tick(); tick();
        checks++; if (song_time !== 14'd0) begin errors++; $display("FAIL done_time_frozen: got %0d want 0", song_time); end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (done !== 1'b1 || addr !== 8'd0) begin
            errors++; $display("FAIL done_ignores_start: done %b addr %0d want 1 0", done, addr);
        end
    endtask

    task automatic test_random();
        int         note_t [12];
        int         t_acc, t_model, idx, cmb, d;
        logic [1:0] exp_res;
        logic       exp_v;
        clear_chart();
        t_acc = 8;
        for (int i = 0; i < 12; i++) begin
            t_acc += int'($urandom_range(10, 30));
            note_t[i] = t_acc;
            chart[i] = {2'b00, 14'(t_acc)};
        end
        restart();
        t_model = 0;
        idx = 0;
        cmb = 0;
        for (int f = 0; f < 1500 && idx < 12; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                d = t_model - note_t[idx];
                if (d >= -3 && d <= 3)      exp_res = 2'b01;
                else if (d >= -6 && d <= 6) exp_res = 2'b10;
                else                        exp_res = 2'b00;
                exp_v = (exp_res != 2'b00);
                key_down = 1'b1;
                step();
                checks++;
                if (judge_valid !== exp_v || (exp_v && judge_result !== exp_res)) begin
                    errors++;
                    $display("FAIL rand_press t=%0d d=%0d: valid %b result %b want %b %b", t_model, d, judge_valid, judge_result, exp_v, exp_res);
                end
                if (exp_v) begin cmb++; idx++; end
                checks++;
                if (int'(combo) != cmb || int'(addr) != idx) begin
                    errors++; $display("FAIL rand_press_state: combo %0d addr %0d want %0d %0d", combo, addr, cmb, idx);
                end
                key_down = 1'b0;
                step();
            end
            if (idx < 12) begin
                tick();
                t_model++;
                exp_v = (t_model - note_t[idx] > 6);
                checks++;
                if (judge_valid !== exp_v || (exp_v && judge_result !== 2'b11) || int'(song_time) != t_model) begin
                    errors++;
                    $display("FAIL rand_tick t=%0d: valid %b result %b time %0d want %b 11 %0d", t_model, judge_valid, judge_result, song_time, exp_v, t_model);
                end
                if (exp_v) begin cmb = 0; idx++; end
                checks++;
                if (int'(combo) != cmb || int'(addr) != idx) begin
                    errors++; $display("FAIL rand_tick_state: combo %0d addr %0d want %0d %0d", combo, addr, cmb, idx);
                end
            end
        end
        checks++;
        if (idx != 12) begin errors++; $display("FAIL rand_budget: judged %0d want 12", idx); end
        step();
        step();
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || int'(song_time) != t_model) begin
            errors++; $display("FAIL rand_end: done %b time %0d want 1 %0d", done, song_time, t_model);
        end
    endtask

    initial begin
        Reset      = 1'b1;
        start      = 1'b0;
        frame_tick = 1'b0;
        key_down   = 1'b0;
        clear_chart();
        test_reset();
        test_tap_perfect();
        test_tap_good_ignore();
        test_miss();
        test_hold();
        test_hold_auto();
        test_reset_mid_hold();
        test_end_marker();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
